// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding and
// timeout defaults used by the RTL and the benches.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int TMO_DEFAULT = 255;
  localparam int WAIT_W      = 8;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the master not granted last time wins,
// otherwise the lone requester wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);

  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~last;
    end else if (req[1]) begin
      win = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU (m0) and a second master (m1) onto one single-port memory,
// with round-robin grants and a sticky timeout flag for a memory that never acks.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err,
  output logic          gnt
);

  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TMO - 1);

  state_t              state;
  state_t              next_state;
  logic                win;
  logic                any_req;
  logic                timeout;
  logic [WAIT_W-1:0]   wait_cnt;

  assign any_req = m0_req | m1_req;
  assign timeout = (wait_cnt == TMO_LAST);

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (gnt),
    .win  (win)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        if (mem_ack || timeout) begin
          next_state = RESP;
        end
      end
      RESP: begin
        m0_ready   = ~gnt;
        m1_ready   = gnt;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // An ack on the last wait cycle still counts as a completed access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      err       <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= win;
            mem_we    <= win ? m1_we    : m0_we;
            mem_addr  <= win ? m1_addr  : m0_addr;
            mem_wdata <= win ? m1_wdata : m0_wdata;
            wait_cnt  <= '0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!mem_we) begin
              if (gnt) begin
                m1_rdata <= mem_rdata;
              end else begin
                m0_rdata <= mem_rdata;
              end
            end
          end else if (timeout) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a short timeout so the
// abort path is reachable in a few cycles.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int TMO_TB = (TMO_DEFAULT > 4) ? 4 : TMO_DEFAULT;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_ready;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_ready;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          err, gnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .AW(AW), .TMO(TMO_TB)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err),
    .gnt       (gnt)
  );

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] rdv;
    bit          drop;
    int          exp_lat;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one access from an IDLE-cycle negedge until the ready pulse; ack_at<0 means never ack.
  task automatic serveNext(input bit exp_m, input bit exp_we, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input int ack_at, input logic [31:0] rdv,
                           input bit drop_req, input bit scramble, output int lat);
    int  busy;
    bit  done;
    busy = 0;
    done = 1'b0;
    lat  = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      mem_ack = 1'b0;
      checkOutput("ready_overlap", 32'(m0_ready & m1_ready), 32'd0);
      if (mem_req) begin
        checkOutput("busy_gnt", 32'(gnt), 32'(exp_m));
        checkOutput("busy_we", 32'(mem_we), 32'(exp_we));
        checkOutput("busy_addr", mem_addr, exp_addr);
        checkOutput("busy_wdata", mem_wdata, exp_wdata);
        if (busy == 0 && scramble) begin
          if (exp_m) begin
            m1_addr = ~m1_addr; m1_wdata = ~m1_wdata; m1_we = ~m1_we;
          end else begin
            m0_addr = ~m0_addr; m0_wdata = ~m0_wdata; m0_we = ~m0_we;
          end
        end
        if (busy == 0 && drop_req) begin
          if (exp_m) m1_req = 1'b0;
          else       m0_req = 1'b0;
        end
        if (busy == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rdv;
        end
        busy++;
      end
      if (m0_ready || m1_ready) begin
        checkOutput("ready_m0", 32'(m0_ready), 32'(!exp_m));
        checkOutput("ready_m1", 32'(m1_ready), 32'(exp_m));
        done = 1'b1;
      end
    end
    if (!done) checkOutput("ready_seen", 32'd0, 32'd1);
  endtask

  task automatic postCheck();
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_one_cycle", 32'(m0_ready | m1_ready), 32'd0);
    checkOutput("idle_no_mem_req", 32'(mem_req), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int lat;
    if (v.m) begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    serveNext(v.m, v.we, v.addr, v.wdata, v.ack_at, v.rdv, v.drop, 1'b1, lat);
    m0_req = 1'b0;
    m1_req = 1'b0;
    checkOutput($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    checkOutput($sformatf("v%0d_m0_rdata", idx), m0_rdata, v.exp_r0);
    checkOutput($sformatf("v%0d_m1_rdata", idx), m1_rdata, v.exp_r1);
    checkOutput($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
    checkOutput($sformatf("v%0d_gnt", idx), 32'(gnt), 32'(v.m));
    postCheck();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 1'b0, 3, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h5A5A5A5A, 0, 32'h11111111, 1'b0, 3, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h24, 32'h0,        2, 32'hCAFEF00D, 1'b0, 5, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h30, 32'h0BADF00D, 1, 32'h22222222, 1'b1, 4, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h40, 32'h0,        3, 32'h12345678, 1'b0, 6, 32'h12345678, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h50, 32'h0,       -1, 32'h99999999, 1'b0, 6, 32'h12345678, 32'hCAFEF00D, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h60, 32'h0,        0, 32'hA5A5A5A5, 1'b0, 3, 32'hA5A5A5A5, 32'hCAFEF00D, 1'b1};

    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_gnt", 32'(gnt), 32'd1);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst_ready", 32'(m0_ready | m1_ready), 32'd0);
    reset = 1'b0;

    // Stray ack with nobody requesting must not move anything.
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("stray_ack_mem_req", 32'(mem_req), 32'd0);
    checkOutput("stray_ack_m0_rdata", m0_rdata, 32'd0);
    checkOutput("stray_ack_ready", 32'(m0_ready | m1_ready), 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset in the middle of BUSY.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h70; m0_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_busy", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_mem_req_drop", 32'(mem_req), 32'd0);
    checkOutput("midrst_err_clear", 32'(err), 32'd0);
    checkOutput("midrst_gnt", 32'(gnt), 32'd1);
    checkOutput("midrst_m0_rdata", m0_rdata, 32'd0);
    m0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_ready", 32'(m0_ready | m1_ready), 32'd0);
      checkOutput("midrst_idle", 32'(mem_req), 32'd0);
    end

    // Simultaneous requests after reset: m0 first, then m1.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h80; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h90; m1_wdata = '0;
    serveNext(1'b0, 1'b0, 32'h80, 32'h0, 0, 32'h0000AAAA, 1'b0, 1'b0, lat);
    m0_req = 1'b0;
    checkOutput("tie_first_lat", 32'(lat), 32'd3);
    checkOutput("tie_first_rdata", m0_rdata, 32'h0000AAAA);
    postCheck();
    serveNext(1'b1, 1'b0, 32'h90, 32'h0, 0, 32'h0000BBBB, 1'b0, 1'b0, lat);
    m1_req = 1'b0;
    checkOutput("tie_second_lat", 32'(lat), 32'd3);
    checkOutput("tie_second_gnt", 32'(gnt), 32'd1);
    checkOutput("tie_second_rdata", m1_rdata, 32'h0000BBBB);
    checkOutput("tie_m0_kept", m0_rdata, 32'h0000AAAA);
    postCheck();

    // Both masters hold requests continuously for six accesses.
    m0_req = 1'b1; m0_addr = 32'h100;
    m1_req = 1'b1; m1_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      bit exp_m;
      exp_m = (i % 2) == 1;
      serveNext(exp_m, 1'b0, exp_m ? 32'h200 : 32'h100, 32'h0, 0, 32'h1000 + 32'(i),
                1'b0, 1'b0, lat);
      if (i == 5) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      checkOutput($sformatf("alt%0d_gnt", i), 32'(gnt), 32'(exp_m));
      if (exp_m) checkOutput($sformatf("alt%0d_m1_rdata", i), m1_rdata, 32'h1000 + 32'(i));
      else       checkOutput($sformatf("alt%0d_m0_rdata", i), m0_rdata, 32'h1000 + 32'(i));
      postCheck();
    end
    checkOutput("final_err_clear", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
